// File: rtl/frame_update_ctrl.sv
// frame_update_ctrl
//   Buffers a 10-byte game-state packet received over SPI and commits it to
//   the game-state register block only during VGA vertical blanking, so the
//   frame being scanned out never sees a half-updated state.
// Ports
//   sys_clk_i     system clock (single domain)
//   sys_rst_i     synchronous active-high reset
//   pkt_start_i   one-cycle pulse at chip-select assert
//   byte_valid_i  one-cycle strobe qualifying byte_i
//   byte_i        received SPI byte
//   vblank_i      high during vertical blanking
//   data_o        committed packet, data_o[0] = ball_x lo ... data_o[9] = score_r
//   data_ready_o  one-cycle strobe, data_o already stable
//   pending_o     complete packet waiting for vblank
//   drop_cnt_o    saturating count of discarded packets
module frame_update_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 50000,
  parameter bit          CHECK_MSB      = 1'b1
) (
  input  logic             sys_clk_i,
  input  logic             sys_rst_i,
  input  logic             pkt_start_i,
  input  logic             byte_valid_i,
  input  logic [7:0]       byte_i,
  input  logic             vblank_i,
  output logic [0:9][7:0]  data_o,
  output logic             data_ready_o,
  output logic             pending_o,
  output logic [7:0]       drop_cnt_o
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_COLLECT = 2'd1;
  localparam logic [1:0] ST_PENDING = 2'd2;
  localparam logic [1:0] ST_COMMIT  = 2'd3;

  logic [1:0]       state;
  logic [0:9][7:0]  shadow;
  logic [3:0]       idx;
  logic [TW-1:0]    tmo_cnt;
  logic             msb_bad;
  logic             last_byte;
  logic             tmo_hit;
  logic             drop_evt;

  // Odd bytes are the high halves of 10-bit coordinates; only bits [1:0]
  // may be set. All odd bytes are already in the shadow when byte 9 lands.
  always_comb begin
    msb_bad   = CHECK_MSB && ((|shadow[1][7:2]) || (|shadow[3][7:2]) ||
                              (|shadow[5][7:2]) || (|shadow[7][7:2]));
    last_byte = (state == ST_COLLECT) && byte_valid_i && (idx == 4'd9);
    tmo_hit   = (state == ST_COLLECT) && !byte_valid_i && (tmo_cnt == TMO_LAST);
    // pkt_start_i outranks the COLLECT-internal drop causes, so at most one
    // drop event can occur per cycle.
    if (pkt_start_i)
      drop_evt = (state == ST_COLLECT) || (state == ST_PENDING);
    else
      drop_evt = (last_byte && msb_bad) || tmo_hit;
  end

  assign pending_o = (state == ST_PENDING);

  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      state        <= ST_IDLE;
      shadow       <= '0;
      idx          <= '0;
      tmo_cnt      <= '0;
      data_o       <= '0;
      data_ready_o <= 1'b0;
      drop_cnt_o   <= '0;
    end else begin
      data_ready_o <= 1'b0;
      if (drop_evt && (drop_cnt_o != 8'hFF))
        drop_cnt_o <= drop_cnt_o + 8'd1;

      // The commit reads the shadow before any same-cycle restart
      // overwrites shadow[0], so a restart during COMMIT loses nothing.
      if (state == ST_COMMIT) begin
        data_o       <= shadow;
        data_ready_o <= 1'b1;
      end

      if (pkt_start_i) begin
        state   <= ST_COLLECT;
        tmo_cnt <= '0;
        if (byte_valid_i) begin
          shadow[0] <= byte_i;
          idx       <= 4'd1;
        end else begin
          idx <= 4'd0;
        end
      end else begin
        case (state)
          ST_COLLECT: begin
            if (byte_valid_i) begin
              shadow[idx] <= byte_i;
              idx         <= idx + 4'd1;
              tmo_cnt     <= '0;
              if (idx == 4'd9)
                state <= msb_bad ? ST_IDLE : ST_PENDING;
            end else if (tmo_hit) begin
              state   <= ST_IDLE;
              idx     <= '0;
              tmo_cnt <= '0;
            end else begin
              tmo_cnt <= tmo_cnt + 1'b1;
            end
          end
          ST_PENDING: if (vblank_i) state <= ST_COMMIT;
          ST_COMMIT:  state <= ST_IDLE;
          default:    state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_frame_update_ctrl.sv
module tb_frame_update_ctrl;

  typedef logic [0:9][7:0] pkt_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        pkt_start = 1'b0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_in = 8'h00;
  logic        vblank = 1'b0;
  pkt_t        data_o;
  logic        data_ready_o;
  logic        pending_o;
  logic [7:0]  drop_cnt_o;

  int checks = 0;
  int failures = 0;
  int pulses = 0;

  // Reference state, updated from the packet-level rules
  pkt_t exp_data;
  int   exp_drop;

  frame_update_ctrl #(.TIMEOUT_CYCLES(100), .CHECK_MSB(1'b1)) dut (
    .sys_clk_i(clk), .sys_rst_i(rst), .pkt_start_i(pkt_start),
    .byte_valid_i(byte_valid), .byte_i(byte_in), .vblank_i(vblank),
    .data_o(data_o), .data_ready_o(data_ready_o), .pending_o(pending_o),
    .drop_cnt_o(drop_cnt_o)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (data_ready_o === 1'b1) pulses++;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int sat_inc(int v);
    return (v >= 255) ? 255 : v + 1;
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic start_pkt(input bit with_byte, input logic [7:0] b);
    pkt_start = 1'b1; byte_valid = with_byte; byte_in = b;
    tick();
    pkt_start = 1'b0; byte_valid = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    byte_valid = 1'b1; byte_in = b;
    tick();
    byte_valid = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic send_pkt(input pkt_t p, input bit combine);
    int first;
    first = combine ? 1 : 0;
    start_pkt(combine, p[0]);
    for (int i = first; i < 10; i++) send_byte(p[i], (i == 9) ? 0 : $urandom_range(0, 3));
  endtask

  task automatic rand_pkt(output pkt_t p);
    for (int i = 0; i < 10; i++) begin
      p[i] = 8'($urandom);
      if (i inside {1, 3, 5, 7}) p[i] = p[i] & 8'h03;
    end
  endtask

  task automatic vblank_cycle();
    vblank = 1'b1; tick(); vblank = 1'b0;
    repeat (3) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; repeat (3) tick(); rst = 1'b0;
    exp_data = '0; exp_drop = 0;
    checks++; if (data_o !== exp_data) begin failures++; $display("FAIL reset_data got=%h exp=%h", data_o, exp_data); end
    checks++; if (data_ready_o !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b exp=0", data_ready_o); end
    checks++; if (pending_o !== 1'b0) begin failures++; $display("FAIL reset_pending got=%b exp=0", pending_o); end
    checks++; if (drop_cnt_o !== 8'd0) begin failures++; $display("FAIL reset_drop got=%0d exp=0", drop_cnt_o); end
  endtask

  task automatic test_nominal();
    pkt_t p;
    int p0;
    p = {8'h20, 8'h01, 8'h40, 8'h00, 8'h10, 8'h00, 8'h30, 8'h00, 8'h03, 8'h05};
    send_pkt(p, 1'b0);
    checks++; if (pending_o !== 1'b1) begin failures++; $display("FAIL nom_pending got=%b exp=1", pending_o); end
    repeat (10) tick();
    checks++; if (data_o !== exp_data) begin failures++; $display("FAIL nom_hold got=%h exp=%h", data_o, exp_data); end
    p0 = pulses;
    vblank = 1'b1; tick(); vblank = 1'b0;
    checks++; if (data_ready_o !== 1'b0) begin failures++; $display("FAIL nom_ready_early got=%b exp=0", data_ready_o); end
    tick();
    checks++; if (data_ready_o !== 1'b1) begin failures++; $display("FAIL nom_ready_lat got=%b exp=1", data_ready_o); end
    checks++; if (data_o !== p) begin failures++; $display("FAIL nom_data got=%h exp=%h", data_o, p); end
    repeat (3) tick();
    exp_data = p;
    checks++; if (pulses - p0 !== 1) begin failures++; $display("FAIL nom_pulses got=%0d exp=1", pulses - p0); end
    checks++; if ({data_o[1], data_o[0]} !== 16'h0120) begin failures++; $display("FAIL nom_ball_x got=%h exp=0120", {data_o[1], data_o[0]}); end
    checks++; if (drop_cnt_o !== 8'd0) begin failures++; $display("FAIL nom_drop got=%0d exp=0", drop_cnt_o); end
  endtask

  task automatic test_validation();
    pkt_t p;
    int p0;
    p = {8'h20, 8'h01, 8'h40, 8'h04, 8'h10, 8'h00, 8'h30, 8'h00, 8'h03, 8'h05};
    p0 = pulses;
    send_pkt(p, 1'b0);
    exp_drop = sat_inc(exp_drop);
    checks++; if (pending_o !== 1'b0) begin failures++; $display("FAIL val_pending got=%b exp=0", pending_o); end
    vblank_cycle();
    checks++; if (pulses - p0 !== 0) begin failures++; $display("FAIL val_pulses got=%0d exp=0", pulses - p0); end
    checks++; if (drop_cnt_o !== 8'(exp_drop)) begin failures++; $display("FAIL val_drop got=%0d exp=%0d", drop_cnt_o, exp_drop); end
    checks++; if (data_o !== exp_data) begin failures++; $display("FAIL val_data got=%h exp=%h", data_o, exp_data); end
  endtask

  task automatic test_timeout();
    pkt_t p;
    int p0;
    rand_pkt(p);
    start_pkt(1'b0, 8'h00);
    for (int i = 0; i < 4; i++) send_byte(p[i], 0);
    repeat (98) tick();
    checks++; if (drop_cnt_o !== 8'(exp_drop)) begin failures++; $display("FAIL tmo_early got=%0d exp=%0d", drop_cnt_o, exp_drop); end
    repeat (3) tick();
    exp_drop = sat_inc(exp_drop);
    checks++; if (drop_cnt_o !== 8'(exp_drop)) begin failures++; $display("FAIL tmo_drop got=%0d exp=%0d", drop_cnt_o, exp_drop); end
    // A late byte must not resurrect the dropped packet.
    send_byte(8'hFF, 0);
    checks++; if (pending_o !== 1'b0) begin failures++; $display("FAIL tmo_pending got=%b exp=0", pending_o); end
    rand_pkt(p);
    p0 = pulses;
    send_pkt(p, 1'b0);
    vblank_cycle();
    exp_data = p;
    checks++; if (data_o !== exp_data || pulses - p0 !== 1) begin failures++; $display("FAIL tmo_recover data=%h exp=%h pulses=%0d exp=1", data_o, exp_data, pulses - p0); end
  endtask

  task automatic test_supersede();
    pkt_t a, b;
    int p0;
    rand_pkt(a); rand_pkt(b);
    p0 = pulses;
    send_pkt(a, 1'b0);
    send_pkt(b, 1'b1);
    exp_drop = sat_inc(exp_drop);
    checks++; if (drop_cnt_o !== 8'(exp_drop)) begin failures++; $display("FAIL sup_drop got=%0d exp=%0d", drop_cnt_o, exp_drop); end
    vblank_cycle();
    exp_data = b;
    checks++; if (data_o !== exp_data) begin failures++; $display("FAIL sup_data got=%h exp=%h", data_o, exp_data); end
    checks++; if (pulses - p0 !== 1) begin failures++; $display("FAIL sup_pulses got=%0d exp=1", pulses - p0); end
  endtask

  task automatic test_vblank_last_byte();
    pkt_t p;
    rand_pkt(p);
    start_pkt(1'b0, 8'h00);
    for (int i = 0; i < 9; i++) send_byte(p[i], 0);
    vblank = 1'b1;
    send_byte(p[9], 0);
    checks++; if (pending_o !== 1'b1 || data_ready_o !== 1'b0) begin failures++; $display("FAIL vbl_pend pending=%b ready=%b exp=1/0", pending_o, data_ready_o); end
    tick();
    checks++; if (data_ready_o !== 1'b0) begin failures++; $display("FAIL vbl_early got=%b exp=0", data_ready_o); end
    tick();
    vblank = 1'b0;
    exp_data = p;
    checks++; if (data_ready_o !== 1'b1 || data_o !== exp_data) begin failures++; $display("FAIL vbl_commit ready=%b data=%h exp=%h", data_ready_o, data_o, exp_data); end
    repeat (2) tick();
  endtask

  task automatic test_commit_restart();
    pkt_t p, q;
    int p0;
    rand_pkt(p); rand_pkt(q);
    send_pkt(p, 1'b0);
    p0 = pulses;
    vblank = 1'b1; tick(); vblank = 1'b0;
    // Now in COMMIT: restart with byte 0 in the same cycle.
    pkt_start = 1'b1; byte_valid = 1'b1; byte_in = q[0];
    tick();
    pkt_start = 1'b0; byte_valid = 1'b0;
    exp_data = p;
    checks++; if (data_ready_o !== 1'b1 || data_o !== exp_data) begin failures++; $display("FAIL cmt_restart ready=%b data=%h exp=%h", data_ready_o, data_o, exp_data); end
    checks++; if (drop_cnt_o !== 8'(exp_drop)) begin failures++; $display("FAIL cmt_drop got=%0d exp=%0d", drop_cnt_o, exp_drop); end
    for (int i = 1; i < 10; i++) send_byte(q[i], $urandom_range(0, 2));
    checks++; if (pending_o !== 1'b1) begin failures++; $display("FAIL cmt_pending got=%b exp=1", pending_o); end
    vblank_cycle();
    exp_data = q;
    checks++; if (data_o !== exp_data || pulses - p0 !== 2) begin failures++; $display("FAIL cmt_second data=%h exp=%h pulses=%0d exp=2", data_o, exp_data, pulses - p0); end
  endtask

  task automatic test_random();
    pkt_t a, b;
    int kind, p0, exp_pulses, bad;
    for (int it = 0; it < 24; it++) begin
      kind = $urandom_range(0, 3);
      rand_pkt(a); rand_pkt(b);
      p0 = pulses;
      exp_pulses = 1;
      case (kind)
        0: send_pkt(a, $urandom_range(0, 1));
        1: begin
          bad = 1 + 2 * $urandom_range(0, 3);
          a[bad] = a[bad] | 8'(4 << $urandom_range(0, 5));
          send_pkt(a, $urandom_range(0, 1));
          exp_drop = sat_inc(exp_drop);
          exp_pulses = 0;
        end
        2: begin
          start_pkt(1'b0, 8'h00);
          repeat ($urandom_range(0, 9)) send_byte(8'($urandom), $urandom_range(0, 2));
          send_pkt(b, $urandom_range(0, 1));
          exp_drop = sat_inc(exp_drop);
          a = b;
        end
        default: begin
          send_pkt(a, 1'b0);
          repeat ($urandom_range(0, 4)) tick();
          send_pkt(b, $urandom_range(0, 1));
          exp_drop = sat_inc(exp_drop);
          a = b;
        end
      endcase
      // Stray strobes while waiting must be ignored.
      repeat ($urandom_range(0, 5)) begin
        byte_valid = $urandom_range(0, 1); byte_in = 8'($urandom); tick();
      end
      byte_valid = 1'b0;
      vblank_cycle();
      if (exp_pulses == 1) exp_data = a;
      checks++; if (data_o !== exp_data || pulses - p0 !== exp_pulses || drop_cnt_o !== 8'(exp_drop)) begin
        failures++;
        $display("FAIL rand_%0d kind=%0d data=%h exp=%h pulses=%0d exp=%0d drop=%0d exp=%0d",
                 it, kind, data_o, exp_data, pulses - p0, exp_pulses, drop_cnt_o, exp_drop);
      end
    end
  endtask

  task automatic test_saturate();
    start_pkt(1'b1, 8'h11);
    for (int i = 0; i < 300; i++) begin
      start_pkt(1'b1, 8'(i));
      exp_drop = sat_inc(exp_drop);
    end
    checks++; if (drop_cnt_o !== 8'(exp_drop) || exp_drop != 255) begin failures++; $display("FAIL sat_drop got=%0d exp=255", drop_cnt_o); end
  endtask

  task automatic test_reset_pending();
    pkt_t p;
    int p0;
    rand_pkt(p);
    send_pkt(p, 1'b0);
    checks++; if (pending_o !== 1'b1) begin failures++; $display("FAIL rstp_pending_pre got=%b exp=1", pending_o); end
    rst = 1'b1; tick(); rst = 1'b0;
    exp_data = '0; exp_drop = 0;
    checks++; if (data_o !== exp_data || pending_o !== 1'b0 || data_ready_o !== 1'b0 || drop_cnt_o !== 8'd0) begin
      failures++;
      $display("FAIL rstp_outputs data=%h pending=%b ready=%b drop=%0d exp=all0", data_o, pending_o, data_ready_o, drop_cnt_o);
    end
    p0 = pulses;
    vblank_cycle();
    checks++; if (pulses - p0 !== 0 || data_o !== exp_data) begin failures++; $display("FAIL rstp_nocommit pulses=%0d exp=0 data=%h", pulses - p0, data_o); end
  endtask

  initial begin
    tick();
    test_reset();
    test_nominal();
    test_validation();
    test_timeout();
    test_supersede();
    test_vblank_last_byte();
    test_commit_restart();
    test_random();
    test_saturate();
    test_reset_pending();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
